bp_be_clint_ctrl: RTL and testbench
===================================

# bp_be_clint_ctrl

Machine-mode timer and software-interrupt controller for the backend MMIO window. Owns the shared `mtime` counter, one `mtimecmp` and one `msip` register per hart, and services single-beat MMIO loads and stores at the fixed CLINT addresses (`mtime` 39'h6f_ffff_0000, `mtimecmp` base 39'h6f_ffff_0100, `msoftint` base 39'h6f_ffff_0200, +8 per hart). It drives level timer and software interrupt lines into each hart's CSR/interrupt logic. It sits between the MMIO request path and the per-hart trap logic.

## Interface
Parameters:
- `num_hart_p`, 1, number of harts (1..32); sets `mtimecmp`/`msip` register count and interrupt vector width.
- `paddr_width_p`, 39, physical address width.
- `dword_width_p`, 64, data width.
- `mtime_div_p`, 8, clock cycles per `mtime` tick (≥1).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk_i`, in, 1, clock.
- `reset_i`, in, 1, asynchronous active-high reset.
- `req_v_i`, in, 1, request valid.
- `req_ready_o`, out, 1, controller can accept a request.
- `req_w_i`, in, 1, 1 = store, 0 = load.
- `req_addr_i`, in, `paddr_width_p`, byte address, 8-byte aligned.
- `req_data_i`, in, `dword_width_p`, store data.
- `resp_v_o`, out, 1, response valid (loads and stores).
- `resp_data_o`, out, `dword_width_p`, load data; 0 for stores.
- `resp_err_o`, out, 1, address unmapped.
- `resp_yumi_i`, in, 1, consumer takes response.
- `timer_irq_o`, out, `num_hart_p`, per-hart MTIP.
- `soft_irq_o`, out, `num_hart_p`, per-hart MSIP.

## Operation
- FSM states: `e_idle` and `e_resp`. `req_ready_o = (state == e_idle)`.
- Request transfer on `req_v_i & req_ready_o` goes to `e_resp`. `resp_yumi_i` in `e_resp` returns the FSM to `e_idle`. `resp_yumi_i` is ignored outside `e_resp`.
- Decode:
  - `mtime`: exact address match.
  - `mtimecmp[h]`: base + 8h, h < `num_hart_p`.
  - `msip[h]`: base + 8h, h < `num_hart_p`.
  - Anything else, including h ≥ `num_hart_p` or a misaligned address: `resp_err_o = 1`, data 0, store discarded.
- Loads latch register contents from the acceptance cycle, before any same-cycle tick.
- `msip` is 1 bit. A store writes `req_data_i[0]`. A load returns it zero-extended.
- Prescaler counts 0..`mtime_div_p-1`. On wrap, `mtime` increments. `mtime` wraps from 2^64-1 to 0.
- A store to `mtime` loads the value and clears the prescaler. This has priority over a same-cycle tick.
- `timer_irq_o[h]` is registered and equals (`mtime >= mtimecmp[h]`, unsigned) from the previous cycle.
- `soft_irq_o[h]` is `msip[h]`.
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - `mtimecmp` = all ones.
  - `msip` = 0.
  - State = `e_idle`.
  - `resp_v_o`, `resp_err_o`, `resp_data_o`, `timer_irq_o`, `soft_irq_o` = 0.
- Reset mid-transaction drops the pending response. No response is issued after reset.

## Timing
- Load/store latency: request accepted at cycle N → `resp_v_o` = 1 at N+1. The response holds stable until `resp_yumi_i`.
- Throughput: 1 request per 2 cycles max. There is no response bypass, so `req_ready_o` is 0 during `e_resp`.
- Store effect:
  - Registers update at the N→N+1 edge.
  - `soft_irq_o` changes at N+1.
  - `timer_irq_o` reflects the new compare at N+2.
- `mtime` tick: increments on the edge ending prescaler value `mtime_div_p-1`. With `mtime_div_p = 1` it increments every cycle.

## Structure
- Add to `bp_be_pkg`:
  - the `bp_be_clint_state_e` enum;
  - `bp_mmio_msoftint_base_addr_gp` (existing);
  - the per-hart stride constant `bp_mmio_clint_stride_gp = 8`.
- Existing address constants are used directly for decode. They are not redefined.
- One sub-module: `bp_be_mtime_counter`. It holds the prescaler plus the 64-bit `mtime`, with load-enable/load-data inputs and a `tick_o` output.
- Decode, registers, FSM and compare logic stay in `bp_be_clint_ctrl`.

## Test plan
- Reset, then load `mtime` with `mtime_div_p = 8`, accepted at cycle 80 after reset release → response data 10, `resp_err_o = 0`, `timer_irq_o = 0`.
- Timer interrupt:
  - Stimulus: store `mtimecmp[0] = 5`, then wait.
  - Required: `timer_irq_o[0]` rises exactly one cycle after `mtime` reaches 5.
  - Then store `mtimecmp[0] = all ones`: irq falls 2 cycles after acceptance.
- Software interrupt with `num_hart_p = 2`:
  - Store 39'h6f_ffff_0208 with data 3 → `soft_irq_o = 2'b10`.
  - Load the same address → data 1.
- `mtime` wrap and overwrite priority:
  - Store `mtime = 64'hFFFF_FFFF_FFFF_FFFF` on a tick cycle → reads back all ones, not incremented.
  - Next tick → 0.
- Unmapped/out-of-range address:
  - Load 39'h6f_ffff_0110 with `num_hart_p = 2` → `resp_err_o = 1`, data 0.
  - Store to the same address → no register changes.
- Backpressure and reset:
  - Hold `resp_yumi_i = 0` for 10 cycles → `req_ready_o` stays 0 and the response is stable.
  - Assert `reset_i` mid-wait → `resp_v_o` goes 0 immediately and `req_ready_o` is 1 after release.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Backend shared definitions: CLINT MMIO address map and controller FSM states.
package bp_be_pkg;

  localparam logic [38:0] bp_mmio_mtime_addr_gp         = 39'h6f_ffff_0000;
  localparam logic [38:0] bp_mmio_mtimecmp_base_addr_gp = 39'h6f_ffff_0100;
  localparam logic [38:0] bp_mmio_msoftint_base_addr_gp = 39'h6f_ffff_0200;
  localparam int          bp_mmio_clint_stride_gp       = 8;

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_be_clint_state_e;

endpackage

// File: rtl/bp_be_mtime_counter.sv
// Free-running mtime counter with a divide-by-div_p prescaler and a load port.
module bp_be_mtime_counter
  import bp_be_pkg::*;
#(
  parameter int width_p = 64,
  parameter int div_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ld_v_i,
  input  logic [width_p-1:0] ld_data_i,
  output logic [width_p-1:0] mtime_o,
  output logic               tick_o
);

  localparam int presc_w_lp = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [presc_w_lp-1:0] presc_max_lp = presc_w_lp'(div_p - 1);

  logic [presc_w_lp-1:0] presc_q, presc_d;
  logic [width_p-1:0]    mtime_q, mtime_d;

  assign tick_o  = (presc_q == presc_max_lp);
  assign mtime_o = mtime_q;

  // A software load wins over a tick landing on the same edge.
  always_comb begin
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    mtime_d = tick_o ? mtime_q + 1'b1 : mtime_q;
    if (ld_v_i) begin
      presc_d = '0;
      mtime_d = ld_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

endmodule

// File: rtl/bp_be_clint_ctrl.sv
// Machine-mode CLINT: mtime, per-hart mtimecmp/msip, single-beat MMIO access and
// level timer/software interrupt outputs.
module bp_be_clint_ctrl
  import bp_be_pkg::*;
#(
  parameter int num_hart_p    = 1,
  parameter int paddr_width_p = 39,
  parameter int dword_width_p = 64,
  parameter int mtime_div_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  // Request/response: a beat moves when valid and ready/yumi are both high.
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [dword_width_p-1:0] req_data_i,
  output logic                     resp_v_o,
  output logic [dword_width_p-1:0] resp_data_o,
  output logic                     resp_err_o,
  input  logic                     resp_yumi_i,
  output logic [num_hart_p-1:0]    timer_irq_o,
  output logic [num_hart_p-1:0]    soft_irq_o,
  output bp_be_clint_state_e       state_o
);

  localparam int hart_w_lp    = (num_hart_p > 1) ? $clog2(num_hart_p) : 1;
  localparam int stride_lg_lp = $clog2(bp_mmio_clint_stride_gp);
  localparam logic [paddr_width_p-1:0] mtime_addr_lp = paddr_width_p'(bp_mmio_mtime_addr_gp);
  localparam logic [paddr_width_p-1:0] cmp_base_lp   = paddr_width_p'(bp_mmio_mtimecmp_base_addr_gp);
  localparam logic [paddr_width_p-1:0] sip_base_lp   = paddr_width_p'(bp_mmio_msoftint_base_addr_gp);
  localparam logic [paddr_width_p-1:0] region_lp     =
    paddr_width_p'(num_hart_p * bp_mmio_clint_stride_gp);

  bp_be_clint_state_e state_q, state_d;

  logic [dword_width_p-1:0] mtimecmp_q [num_hart_p];
  logic [dword_width_p-1:0] mtimecmp_d [num_hart_p];
  logic [num_hart_p-1:0]    msip_q, msip_d;
  logic [num_hart_p-1:0]    timer_irq_q, timer_irq_d;
  logic [dword_width_p-1:0] resp_data_q, resp_data_d;
  logic                     resp_err_q, resp_err_d;

  logic [dword_width_p-1:0] mtime;
  logic                     mtime_tick_unused;
  logic [paddr_width_p-1:0] cmp_off, sip_off;
  logic [hart_w_lp-1:0]     cmp_idx, sip_idx;
  logic                     mtime_hit, cmp_hit, sip_hit, hit;
  logic                     xfer, store_v;
  logic [dword_width_p-1:0] rdata;

  // Per-hart windows must be in range and stride-aligned; anything else is an error.
  assign cmp_off   = req_addr_i - cmp_base_lp;
  assign sip_off   = req_addr_i - sip_base_lp;
  assign mtime_hit = (req_addr_i == mtime_addr_lp);
  assign cmp_hit   = (req_addr_i >= cmp_base_lp) && (cmp_off < region_lp)
                     && (cmp_off[stride_lg_lp-1:0] == '0);
  assign sip_hit   = (req_addr_i >= sip_base_lp) && (sip_off < region_lp)
                     && (sip_off[stride_lg_lp-1:0] == '0);
  assign cmp_idx   = cmp_off[stride_lg_lp +: hart_w_lp];
  assign sip_idx   = sip_off[stride_lg_lp +: hart_w_lp];
  assign hit       = mtime_hit | cmp_hit | sip_hit;

  assign req_ready_o = (state_q == e_idle);
  assign xfer        = req_v_i & req_ready_o;
  assign store_v     = xfer & req_w_i;

  bp_be_mtime_counter #(
    .width_p(dword_width_p),
    .div_p  (mtime_div_p)
  ) u_mtime (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .ld_v_i   (store_v & mtime_hit),
    .ld_data_i(req_data_i),
    .mtime_o  (mtime),
    .tick_o   (mtime_tick_unused)
  );

  always_comb begin
    rdata = '0;
    if (mtime_hit)    rdata = mtime;
    else if (cmp_hit) rdata = mtimecmp_q[cmp_idx];
    else if (sip_hit) rdata = dword_width_p'(msip_q[sip_idx]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      e_idle:  if (req_v_i) state_d = e_resp;
      e_resp:  if (resp_yumi_i) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // Load data is captured from pre-edge register contents, so same-cycle updates are not seen.
  always_comb begin
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    if (store_v && cmp_hit) mtimecmp_d[cmp_idx] = req_data_i;
    if (store_v && sip_hit) msip_d[sip_idx] = req_data_i[0];
    if (xfer) begin
      resp_data_d = req_w_i ? '0 : rdata;
      resp_err_d  = ~hit;
    end
    for (int h = 0; h < num_hart_p; h++) begin
      timer_irq_d[h] = (mtime >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      msip_q      <= '0;
      timer_irq_q <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int h = 0; h < num_hart_p; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      state_q     <= state_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mtimecmp_q  <= mtimecmp_d;
    end
  end

  assign resp_v_o    = (state_q == e_resp);
  assign resp_data_o = resp_data_q;
  assign resp_err_o  = resp_err_q;
  assign timer_irq_o = timer_irq_q;
  assign soft_irq_o  = msip_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bp_be_clint_ctrl.sv
// Self-checking bench for bp_be_clint_ctrl: directed CLINT scenarios plus random MMIO traffic
// compared every cycle against a time-based behavioural model.
module tb_bp_be_clint_ctrl;
  import bp_be_pkg::*;

  localparam int NH  = 2;
  localparam int DIV = 8;
  localparam logic [38:0] A_MTIME = 39'h6f_ffff_0000;
  localparam logic [38:0] A_CMP   = 39'h6f_ffff_0100;
  localparam logic [38:0] A_SIP   = 39'h6f_ffff_0200;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic          req_v = 1'b0, req_w = 1'b0, resp_yumi = 1'b0;
  logic [38:0]   req_addr = '0;
  logic [63:0]   req_data = '0;
  logic          req_ready, resp_v, resp_err;
  logic [63:0]   resp_data;
  logic [NH-1:0] timer_irq, soft_irq;
  bp_be_clint_state_e dbg_state;

  bp_be_clint_ctrl #(
    .num_hart_p   (NH),
    .paddr_width_p(39),
    .dword_width_p(64),
    .mtime_div_p  (DIV)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .req_v_i    (req_v),
    .req_ready_o(req_ready),
    .req_w_i    (req_w),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .resp_v_o   (resp_v),
    .resp_data_o(resp_data),
    .resp_err_o (resp_err),
    .resp_yumi_i(resp_yumi),
    .timer_irq_o(timer_irq),
    .soft_irq_o (soft_irq),
    .state_o    (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // mtime is a pure function of time since the last load: value + elapsed/DIV.
  bit            m_busy;
  logic [63:0]   m_load_val;
  longint        m_load_cyc;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_prev_ge;
  logic [64:0]   exp_q[$];

  function automatic logic [63:0] m_mtime(input longint c);
    return m_load_val + 64'((c - m_load_cyc) / DIV);
  endfunction

  function automatic void m_decode(input logic [38:0] a, output int kind, output int h);
    kind = 0;
    h    = 0;
    if (a == A_MTIME) kind = 1;
    else if (a[2:0] == 3'd0 && a >= A_CMP && a < A_CMP + 39'(8 * NH)) begin
      kind = 2;
      h    = int'((a - A_CMP) >> 3);
    end else if (a[2:0] == 3'd0 && a >= A_SIP && a < A_SIP + 39'(8 * NH)) begin
      kind = 3;
      h    = int'((a - A_SIP) >> 3);
    end
  endfunction

  task automatic m_reset();
    m_busy     = 1'b0;
    m_load_val = '0;
    m_load_cyc = 0;
    for (int h = 0; h < NH; h++) m_cmp[h] = ONES;
    m_msip    = '0;
    m_prev_ge = '0;
    exp_q.delete();
  endtask

  initial m_reset();

  always @(negedge clk) begin : compare
    logic [NH-1:0] ge;
    logic [63:0]   rd;
    int            kind, h;
    if (rst) begin
      m_reset();
    end else begin
      chk("req_ready", req_ready, !m_busy);
      chk("resp_v", resp_v, m_busy);
      chk("dbg_state", dbg_state, m_busy ? e_resp : e_idle);
      if (m_busy) begin
        chk("resp_data", resp_data, exp_q[0][63:0]);
        chk("resp_err", resp_err, exp_q[0][64]);
      end
      chk("soft_irq", soft_irq, m_msip);
      chk("timer_irq", timer_irq, m_prev_ge);
      for (int i = 0; i < NH; i++) ge[i] = (m_mtime(cyc) >= m_cmp[i]);
      if (m_busy) begin
        if (resp_yumi) begin
          m_busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (req_v) begin
        m_decode(req_addr, kind, h);
        rd = '0;
        case (kind)
          1: rd = m_mtime(cyc);
          2: rd = m_cmp[h];
          3: rd = {63'b0, m_msip[h]};
          default: ;
        endcase
        if (req_w) begin
          rd = '0;
          case (kind)
            1: begin m_load_val = req_data; m_load_cyc = cyc + 1; end
            2: m_cmp[h] = req_data;
            3: m_msip[h] = req_data[0];
            default: ;
          endcase
        end
        exp_q.push_back({kind == 0, rd});
        m_busy = 1'b1;
      end
      m_prev_ge = ge;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_v = 1'b0;
    resp_yumi = 1'b0;
    tick_n(3);
    rst = 1'b0;
  endtask

  // Called just after a clock edge with the controller idle; returns one cycle after the yumi cycle.
  task automatic do_req(input logic w, input logic [38:0] a, input logic [63:0] d,
                        input int yumi_dly, input bit noise,
                        output logic [63:0] rd, output logic re, output longint acc);
    req_v = 1'b1; req_w = w; req_addr = a; req_data = d; resp_yumi = 1'b0;
    acc = cyc;
    tick_n(1);
    req_v = 1'b0;
    rd = resp_data;
    re = resp_err;
    repeat (yumi_dly) begin
      if (noise) begin
        req_v = 1'b1; req_w = 1'b1; req_addr = A_CMP; req_data = {$urandom, $urandom};
      end
      tick_n(1);
    end
    resp_yumi = 1'b1;
    tick_n(1);
    resp_yumi = 1'b0;
    req_v = 1'b0;
  endtask

  function automatic logic [38:0] rand_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return A_MTIME;
      1: return A_CMP;
      2: return A_CMP + 39'd8;
      3: return A_SIP;
      4: return A_SIP + 39'd8;
      5: return A_CMP + 39'd16;
      6: return A_SIP + 39'd16;
      7: return A_CMP + 39'd4;
      8: return t[38:0] & ~39'h7;
      default: return A_MTIME + 39'd8;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [63:0] rd, d;
    logic        re;
    longint      acc, accs, rise;
    logic [38:0] a;

    tick_n(1);
    chk("reset_resp_v", resp_v, 1'b0);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_timer_irq", timer_irq, '0);
    chk("reset_soft_irq", soft_irq, '0);
    chk("reset_resp_data", resp_data, '0);
    chk("reset_resp_err", resp_err, 1'b0);
    tick_n(2);
    rst = 1'b0;

    // mtime load accepted at cycle 80 reads 80/8 = 10
    while (cyc < 80) tick_n(1);
    do_req(1'b0, A_MTIME, '0, 0, 1'b0, rd, re, acc);
    chk("mtime_load_cycle80", rd, 64'd10);
    chk("mtime_load_err", re, 1'b0);
    chk("mtime_load_irq", timer_irq, '0);

    // mtimecmp[0] = 5: mtime reaches 5 at cycle 40, irq at 41
    do_reset();
    do_req(1'b1, A_CMP, 64'd5, 0, 1'b0, rd, re, acc);
    rise = -1;
    while (cyc < 60) begin
      if (timer_irq[0] && rise < 0) rise = cyc;
      tick_n(1);
    end
    chk("timer_rise_cycle", 64'(rise), 64'd41);
    do_req(1'b1, A_CMP, ONES, 0, 1'b0, rd, re, acc);
    chk("timer_fall_at_n2", timer_irq[0], 1'b0);

    // software interrupt, hart 1
    do_req(1'b1, A_SIP + 39'd8, 64'd3, 0, 1'b0, rd, re, acc);
    chk("soft_irq_store", soft_irq, 2'b10);
    do_req(1'b0, A_SIP + 39'd8, '0, 0, 1'b0, rd, re, acc);
    chk("msip_load", rd, 64'd1);
    chk("msip_load_err", re, 1'b0);

    // mtime store on a tick cycle wins, then wraps on the following tick
    while (((cyc - m_load_cyc) % DIV) != DIV - 1) tick_n(1);
    do_req(1'b1, A_MTIME, ONES, 0, 1'b0, rd, re, accs);
    do_req(1'b0, A_MTIME, '0, 0, 1'b0, rd, re, acc);
    chk("mtime_overwrite", rd, ONES);
    while (cyc < accs + 12) tick_n(1);
    do_req(1'b0, A_MTIME, '0, 0, 1'b0, rd, re, acc);
    chk("mtime_wrap", rd, 64'd0);

    // out-of-range hart and misaligned/unmapped accesses
    do_req(1'b0, A_CMP + 39'd16, '0, 0, 1'b0, rd, re, acc);
    chk("unmapped_load_err", re, 1'b1);
    chk("unmapped_load_data", rd, 64'd0);
    do_req(1'b1, A_CMP + 39'd16, 64'h1234, 0, 1'b0, rd, re, acc);
    chk("unmapped_store_err", re, 1'b1);
    do_req(1'b1, A_SIP + 39'd16, 64'h1, 1, 1'b0, rd, re, acc);
    chk("unmapped_sip_store_irq", soft_irq, 2'b10);
    do_req(1'b0, A_CMP + 39'd8, '0, 0, 1'b0, rd, re, acc);
    chk("cmp1_untouched", rd, ONES);
    do_req(1'b0, A_CMP, '0, 0, 1'b0, rd, re, acc);
    chk("cmp0_untouched", rd, ONES);

    // backpressure then reset mid-wait
    req_v = 1'b1; req_w = 1'b0; req_addr = A_CMP + 39'd8;
    tick_n(1);
    req_v = 1'b0;
    d = resp_data;
    chk("bp_data", d, ONES);
    for (int i = 0; i < 10; i++) begin
      req_v = 1'b1; req_w = 1'b1; req_addr = A_SIP; req_data = 64'h1;
      chk("bp_ready_low", req_ready, 1'b0);
      chk("bp_data_stable", resp_data, ONES);
      tick_n(1);
    end
    req_v = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_drops_resp_v", resp_v, 1'b0);
    tick_n(2);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_resp_v", resp_v, 1'b0);

    // random traffic
    for (int t = 0; t < 250; t++) begin
      a = rand_addr();
      d = {$urandom, $urandom};
      if (a == A_CMP || a == A_CMP + 39'd8) d = m_mtime(cyc) + 64'($urandom_range(0, 4));
      if (a == A_MTIME && $urandom_range(0, 3) == 0) d = ONES - 64'($urandom_range(0, 2));
      else if (a == A_MTIME && $urandom_range(0, 1) == 0) d = 64'($urandom_range(0, 20));
      do_req($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, rd, re, acc);
      repeat ($urandom_range(0, 2)) begin
        resp_yumi = $urandom_range(0, 1) == 1;
        tick_n(1);
      end
      resp_yumi = 1'b0;
    end
    tick_n(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
